// File: rtl/ans_pkg.sv
// Shared constants, loader state encoding and bus packing helpers for the ANS
// table loader and its prefix-sum engine.
package ans_pkg;

  localparam int SYM_WIDTH   = 4;
  localparam int CNT_WIDTH   = 8;
  localparam int SYM_COUNT   = 16;
  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_CHECK = 3'd3,
    ST_READY = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_t;

  // Lowest bit of entry idx in a flat bus of width-bit entries.
  function automatic int pack_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  // Pointer width that stays at least one bit for single-entry ranges.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ans_prefix_accum.sv
// Sequential inclusive prefix sum over the per-symbol counts: one symbol per
// cycle after i_start, o_done high during the cycle that writes the last entry.
module ans_prefix_accum #(
  parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH,
  parameter int SYM_COUNT = ans_pkg::SYM_COUNT,
  parameter int CNT_WIDTH = ans_pkg::CNT_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_clear,
  input  logic                                       i_start,
  input  logic [CNT_WIDTH*SYM_COUNT-1:0]             i_counts,
  output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] o_cum,
  output logic                                       o_done,
  output logic [CNT_WIDTH+SYM_WIDTH-1:0]             o_total
);
  import ans_pkg::*;

  localparam int CUM_W = CNT_WIDTH + SYM_WIDTH;
  localparam int IDX_W = ptr_width(SYM_COUNT);

  logic [CNT_WIDTH-1:0] w_counts [SYM_COUNT];
  logic [CUM_W-1:0]     r_cum    [SYM_COUNT];
  logic                 r_busy;
  logic [IDX_W-1:0]     r_idx;
  logic [CUM_W-1:0]     r_acc;
  logic [CUM_W-1:0]     w_sum;
  logic                 w_last;

  generate
    for (genvar gi = 0; gi < SYM_COUNT; gi++) begin : g_bus
      assign w_counts[gi] = i_counts[pack_lsb(gi, CNT_WIDTH) +: CNT_WIDTH];
      assign o_cum[pack_lsb(gi, CUM_W) +: CUM_W] = r_cum[gi];
    end
  endgenerate

  assign w_last  = (r_idx == IDX_W'(SYM_COUNT - 1));
  assign w_sum   = r_acc + {{SYM_WIDTH{1'b0}}, w_counts[r_idx]};
  assign o_done  = r_busy && w_last;
  assign o_total = r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_busy <= 1'b0;
      r_idx  <= '0;
      r_acc  <= '0;
      for (int k = 0; k < SYM_COUNT; k++) r_cum[k] <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_idx  <= '0;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_cum[r_idx] <= w_sum;
      r_acc        <= w_sum;
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ans_table_loader.sv
// Loads the ANS frequency table from a nibble stream, builds the cumulative
// table and releases the decoder only once both tables are valid.
module ans_table_loader #(
  parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH,
  parameter int SYM_COUNT = ans_pkg::SYM_COUNT,
  parameter int CNT_WIDTH = ans_pkg::CNT_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_cfg_start,
  input  logic [SYM_WIDTH-1:0]                       i_in,
  input  logic                                       i_in_vld,
  output logic                                       o_in_rdy,
  output logic [CNT_WIDTH*SYM_COUNT-1:0]             o_counts_unpacked,
  output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] o_cumulative_unpacked,
  output logic                                       o_tables_vld,
  output logic                                       o_dec_rst_n,
  output logic                                       o_dec_en,
  output logic                                       o_busy,
  output logic                                       o_err
);
  import ans_pkg::*;

  localparam int CUM_W     = CNT_WIDTH + SYM_WIDTH;
  localparam int NIBS      = CNT_WIDTH / SYM_WIDTH;
  localparam int SYM_PTR_W = ptr_width(SYM_COUNT);
  localparam int NIB_PTR_W = ptr_width(NIBS);

  loader_state_t        r_state;
  logic [CNT_WIDTH-1:0] r_counts [SYM_COUNT];
  logic [SYM_PTR_W-1:0] r_sym_ptr;
  logic [NIB_PTR_W-1:0] r_nib_ptr;
  logic                 r_in_rdy;
  logic                 r_tables_vld;
  logic                 r_dec_rst_n;
  logic                 r_dec_en;
  logic                 r_busy;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_last_nib;
  logic                 w_last_sym;
  logic                 w_reload;
  logic                 w_accum_start;
  logic                 w_accum_done;
  logic [CUM_W-1:0]     w_total;

  assign w_accept      = (r_state == ST_LOAD) && i_in_vld && r_in_rdy;
  assign w_last_nib    = (r_nib_ptr == NIB_PTR_W'(NIBS - 1));
  assign w_last_sym    = (r_sym_ptr == SYM_PTR_W'(SYM_COUNT - 1));
  // cfg_start only counts when no load is in flight.
  assign w_reload      = i_cfg_start &&
                         (r_state == ST_IDLE || r_state == ST_READY || r_state == ST_ERROR);
  assign w_accum_start = w_accept && w_last_nib && w_last_sym;

  generate
    for (genvar gi = 0; gi < SYM_COUNT; gi++) begin : g_counts
      assign o_counts_unpacked[pack_lsb(gi, CNT_WIDTH) +: CNT_WIDTH] = r_counts[gi];
    end
  endgenerate

  ans_prefix_accum #(
    .SYM_WIDTH (SYM_WIDTH),
    .SYM_COUNT (SYM_COUNT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_reload),
    .i_start  (w_accum_start),
    .i_counts (o_counts_unpacked),
    .o_cum    (o_cumulative_unpacked),
    .o_done   (w_accum_done),
    .o_total  (w_total)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sym_ptr    <= '0;
      r_nib_ptr    <= '0;
      r_in_rdy     <= 1'b0;
      r_tables_vld <= 1'b0;
      r_dec_rst_n  <= 1'b0;
      r_dec_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      for (int k = 0; k < SYM_COUNT; k++) r_counts[k] <= '0;
    end else if (w_reload) begin
      r_state      <= ST_LOAD;
      r_sym_ptr    <= '0;
      r_nib_ptr    <= '0;
      r_in_rdy     <= 1'b1;
      r_tables_vld <= 1'b0;
      r_dec_rst_n  <= 1'b0;
      r_dec_en     <= 1'b0;
      r_busy       <= 1'b1;
      r_err        <= 1'b0;
      for (int k = 0; k < SYM_COUNT; k++) r_counts[k] <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            for (int k = 0; k < NIBS; k++) begin
              if (r_nib_ptr == NIB_PTR_W'(k)) r_counts[r_sym_ptr][k*SYM_WIDTH +: SYM_WIDTH] <= i_in;
            end
            if (w_last_nib) begin
              r_nib_ptr <= '0;
              if (w_last_sym) begin
                r_sym_ptr <= '0;
                r_in_rdy  <= 1'b0;
                r_state   <= ST_ACCUM;
              end else begin
                r_sym_ptr <= r_sym_ptr + 1'b1;
              end
            end else begin
              r_nib_ptr <= r_nib_ptr + 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (w_accum_done) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          r_busy <= 1'b0;
          // Final running total equals the last cumulative entry.
          if (w_total == '0) begin
            r_state <= ST_ERROR;
            r_err   <= 1'b1;
          end else begin
            r_state      <= ST_READY;
            r_tables_vld <= 1'b1;
            r_dec_rst_n  <= 1'b1;
            r_dec_en     <= 1'b1;
          end
        end
        ST_IDLE, ST_READY, ST_ERROR: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_rdy     = r_in_rdy;
  assign o_tables_vld = r_tables_vld;
  assign o_dec_rst_n  = r_dec_rst_n;
  assign o_dec_en     = r_dec_en;
  assign o_busy       = r_busy;
  assign o_err        = r_err;

endmodule

// File: tb/tb_ans_table_loader.sv
// Scoreboard bench for ans_table_loader: the driver streams tables and queues
// the expected outcome, a negedge monitor checks each completed table.
module tb_ans_table_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [3:0]   nib;
  logic         in_vld;
  logic         in_rdy;
  logic [127:0] counts_bus;
  logic [191:0] cum_bus;
  logic         tables_vld;
  logic         dec_rst_n;
  logic         dec_en;
  logic         busy;
  logic         err;

  ans_table_loader dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_cfg_start           (cfg_start),
    .i_in                  (nib),
    .i_in_vld              (in_vld),
    .o_in_rdy              (in_rdy),
    .o_counts_unpacked     (counts_bus),
    .o_cumulative_unpacked (cum_bus),
    .o_tables_vld          (tables_vld),
    .o_dec_rst_n           (dec_rst_n),
    .o_dec_en              (dec_en),
    .o_busy                (busy),
    .o_err                 (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0][7:0]  cnt;
    logic [15:0][11:0] cum;
    logic              ok;
    int                done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: cumulative table is the running sum of the counts.
  function automatic exp_t model(input logic [15:0][7:0] c);
    exp_t e;
    int run;
    e = '0;
    run = 0;
    e.cnt = c;
    for (int j = 0; j < 16; j++) begin
      run += int'(c[j]);
      e.cum[j] = 12'(run);
    end
    e.ok = (run > 0);
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_rdy"}, in_rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tables_vld"}, tables_vld, 0);
    chk({tag, "_dec_rst_n"}, dec_rst_n, 0);
    chk({tag, "_dec_en"}, dec_en, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_counts"}, counts_bus, 0);
    chk({tag, "_cum"}, cum_bus, 0);
  endtask

  // gap_mode: 0 = in_vld held high, 1 = one idle cycle before each nibble,
  // 2 = random 0..2 idle cycles. poke pulses cfg_start during LOAD and ACCUM.
  task automatic run_load(input logic [15:0][7:0] c, input int gap_mode, input bit poke);
    int   stalls;
    int   c0;
    int   g;
    bit   found;
    logic [7:0] byte_v;
    exp_t e;
    stalls = 0;
    @(negedge clk);
    cfg_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("entry_in_rdy", in_rdy, 1);
    chk("entry_busy", busy, 1);
    chk("entry_tables_vld", tables_vld, 0);
    chk("entry_dec_rst_n", dec_rst_n, 0);
    chk("entry_dec_en", dec_en, 0);
    chk("entry_err", err, 0);
    chk("entry_counts_clr", counts_bus, 0);
    chk("entry_cum_clr", cum_bus, 0);
    for (int n = 0; n < 32; n++) begin
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < g; s++) begin
        in_vld = 1'b0;
        nib = 4'($urandom);
        @(negedge clk);
        chk("stall_in_rdy", in_rdy, 1);
        stalls++;
      end
      byte_v = c[n/2];
      in_vld = 1'b1;
      nib = byte_v[(n%2)*4 +: 4];
      if (poke && n == 5) cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    in_vld = 1'b0;
    nib = 4'($urandom);
    e = model(c);
    e.done_cyc = c0 + 50 + stalls;
    sb_q.push_back(e);
    if (poke) begin
      repeat (2) @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tables_vld || err) begin
        found = 1'b1;
        break;
      end
    end
    chk("done_timeout", found, 1);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: one scoreboard entry per completed load (tables_vld or err rising).
  always @(negedge clk) begin
    if (!rst && (tables_vld || err) && !prev_done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: completion at cycle %0d with empty scoreboard", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("latency_cycle", cyc, mon_e.done_cyc);
        chk("tables_vld", tables_vld, mon_e.ok);
        chk("err", err, !mon_e.ok);
        chk("dec_rst_n", dec_rst_n, mon_e.ok);
        chk("dec_en", dec_en, mon_e.ok);
        chk("busy_done", busy, 0);
        chk("in_rdy_done", in_rdy, 0);
        chk("counts_table", counts_bus, mon_e.cnt);
        chk("cum_table", cum_bus, mon_e.cum);
        chk("cum_last", cum_bus[191:180], mon_e.cum[15]);
      end
    end
    prev_done <= tables_vld || err;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0][7:0] tbl;
    rst = 1'b1;
    cfg_start = 1'b0;
    nib = 4'd0;
    in_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int j = 0; j < 16; j++) tbl[j] = 8'(j + 1);
    run_load(tbl, 0, 1'b0);
    $display("load ascending, in_vld held high");
    run_load(tbl, 1, 1'b0);
    $display("load ascending, in_vld toggling");

    tbl = '0;
    run_load(tbl, 0, 1'b0);
    $display("load all-zero table");
    chk("error_hold_err", err, 1);
    chk("error_hold_dec_rst_n", dec_rst_n, 0);

    for (int j = 0; j < 16; j++) tbl[j] = 8'd1;
    tbl[0] = 8'd255;
    run_load(tbl, 0, 1'b0);
    $display("reload from error: counts[0]=255, rest 1");

    tbl = '0;
    tbl[3] = 8'd8;
    run_load(tbl, 0, 1'b0);
    $display("reload from ready: 8 on symbol 3");

    for (int j = 0; j < 16; j++) tbl[j] = 8'($urandom);
    run_load(tbl, 0, 1'b1);
    $display("load with cfg_start pulses in LOAD and ACCUM");

    // Reset partway through a load, then stray nibbles must be ignored.
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      in_vld = 1'b1;
      nib = 4'($urandom_range(1, 15));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midload_reset");
    for (int n = 0; n < 8; n++) begin
      in_vld = 1'b1;
      nib = 4'($urandom_range(1, 15));
      @(negedge clk);
    end
    in_vld = 1'b0;
    chk("post_reset_in_rdy", in_rdy, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_counts", counts_bus, 0);
    $display("reset after 10 nibbles, stray nibbles ignored");

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 16; j++) tbl[j] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      run_load(tbl, 2, 1'b0);
      $display("random load %0d with random gaps", r);
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
